// File: rtl/regfile_2r1w.sv
// Purpose : DEPTH x WIDTH register file, two combinational read ports (A, B), one write port (D).
// Latency : reads 0 cycles (combinational); writes visible after the next rising clk edge.
// Backpressure: none; every port is always ready, illegal writes are silently dropped.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle legal write to matching read ports.
module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    aaddr,
    input  logic [AW-1:0]    baddr,
    input  logic [AW-1:0]    daddr,
    input  logic             dwe,
    input  logic [WIDTH-1:0] dbus,
    output logic [WIDTH-1:0] abus,
    output logic [WIDTH-1:0] bbus
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] a_stored;
    logic [WIDTH-1:0] b_stored;

    // Address lies inside the implemented storage (DEPTH need not be a power of two).
    function automatic logic in_range(input logic [AW-1:0] addr);
        return int'(addr) < DEPTH;
    endfunction

    // Address names the hardwired-zero register when that option is enabled.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // A write only lands when enabled, not in reset, in range and not aimed at a hardwired zero.
    always_comb begin
        wr_ok = dwe && !reset && in_range(daddr) && !is_zero_reg(daddr);
    end

    // Storage: reset clears every register and beats a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[daddr] <= dbus;
        end
    end

    // Port A stored value; out-of-range and hardwired-zero addresses read as zero.
    always_comb begin
        a_stored = '0;
        if (in_range(aaddr) && !is_zero_reg(aaddr)) begin
            a_stored = regs[aaddr];
        end
    end

    // Port B stored value; same rules as port A.
    always_comb begin
        b_stored = '0;
        if (in_range(baddr) && !is_zero_reg(baddr)) begin
            b_stored = regs[baddr];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through: a legal write in flight is forwarded so decode need not stall on writeback.
    always_comb begin
        abus = a_stored;
        bbus = b_stored;
        if (wr_ok && (aaddr == daddr)) begin
            abus = dbus;
        end
        if (wr_ok && (baddr == daddr)) begin
            bbus = dbus;
        end
    end
`else
    // No forwarding: a same-cycle read returns the value stored before the edge.
    always_comb begin
        abus = a_stored;
        bbus = b_stored;
    end
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: three configurations (32/zero-reg, 32/plain, 24/zero-reg) share one stimulus.
// A behavioural array model predicts every read; literal checks pin the model on directed cases.
// Build with or without REGFILE_BYPASS_EN; the model follows the same macro.
module tb_regfile_2r1w;

    localparam int NI = 3;

    logic        clk;
    logic        reset;
    logic [4:0]  aaddr;
    logic [4:0]  baddr;
    logic [4:0]  daddr;
    logic        dwe;
    logic [31:0] dbus;
    logic [31:0] abus_w [NI];
    logic [31:0] bbus_w [NI];

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 0;

    // Model state per configuration.
    logic [31:0] m [NI][32];
    int depth_of [NI] = '{32, 32, 24};
    int zr_of    [NI] = '{1, 0, 1};

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut0 (
        .clk(clk), .reset(reset), .aaddr(aaddr), .baddr(baddr), .daddr(daddr),
        .dwe(dwe), .dbus(dbus), .abus(abus_w[0]), .bbus(bbus_w[0]));

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut1 (
        .clk(clk), .reset(reset), .aaddr(aaddr), .baddr(baddr), .daddr(daddr),
        .dwe(dwe), .dbus(dbus), .abus(abus_w[1]), .bbus(bbus_w[1]));

    regfile_2r1w #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1)) dut2 (
        .clk(clk), .reset(reset), .aaddr(aaddr), .baddr(baddr), .daddr(daddr),
        .dwe(dwe), .dbus(dbus), .abus(abus_w[2]), .bbus(bbus_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit legal_write(int inst);
        return dwe && !reset && (int'(daddr) < depth_of[inst])
               && !(zr_of[inst] != 0 && daddr == 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(int inst, logic [4:0] addr);
        if (int'(addr) >= depth_of[inst]) return 32'h0;
        if (zr_of[inst] != 0 && addr == 5'd0) return 32'h0;
        if (BYPASS && legal_write(inst) && addr == daddr) return dbus;
        return m[inst][addr];
    endfunction

    // Model update on the edge: reset clears all, otherwise legal writes land.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) m[i][r] = 32'h0;
            end else if (legal_write(i)) begin
                m[i][daddr] = dbus;
            end
        end
    end

    // Every cycle after the first reset: both ports of every configuration against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < NI; i++) begin
                logic [31:0] ea, eb;
                ea = exp_read(i, aaddr);
                eb = exp_read(i, baddr);
                n_cmp++;
                if (abus_w[i] !== ea) begin
                    n_bad++;
                    $display("FAIL model_a inst=%0d aaddr=%0d got=%h exp=%h t=%0t", i, aaddr, abus_w[i], ea, $time);
                end
                n_cmp++;
                if (bbus_w[i] !== eb) begin
                    n_bad++;
                    $display("FAIL model_b inst=%0d baddr=%0d got=%h exp=%h t=%0t", i, baddr, bbus_w[i], eb, $time);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        dwe = 1'b1;
        daddr = a;
        dbus = d;
        tick();
        dwe = 1'b0;
    endtask

    initial begin
        reset = 1'b0; dwe = 1'b0; aaddr = '0; baddr = '0; daddr = '0; dbus = '0;
        tick();

        // Reset, then sweep every address on both ports.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checking = 1'b1;
        for (int i = 0; i < 32; i++) begin
            aaddr = 5'(i);
            baddr = 5'(31 - i);
            @(negedge clk);
            check_lit("rst_a", abus_w[0], 32'h0);
            check_lit("rst_b", bbus_w[1], 32'h0);
            tick();
        end

        // Write k = 1..31, then read k on A and 32-k on B.
        for (int k = 1; k < 32; k++) do_write(5'(k), 32'hA5A50000 + k);
        for (int k = 1; k < 32; k++) begin
            aaddr = 5'(k);
            baddr = 5'(32 - k);
            @(negedge clk);
            check_lit("wr_rd_a", abus_w[0], 32'hA5A50000 + k);
            check_lit("wr_rd_b", bbus_w[0], 32'hA5A50000 + (32 - k));
            tick();
        end

        // Register 0: hardwired zero vs ordinary storage.
        do_write(5'd0, 32'hFFFFFFFF);
        aaddr = 5'd0;
        @(negedge clk);
        check_lit("zero_reg_on", abus_w[0], 32'h0);
        check_lit("zero_reg_off", abus_w[1], 32'hFFFFFFFF);
        tick();

        // Non-power-of-two depth: out-of-range write dropped, neighbours untouched.
        do_write(5'd30, 32'hDEADBEEF);
        aaddr = 5'd30;
        baddr = 5'd23;
        @(negedge clk);
        check_lit("d24_oor_read", abus_w[2], 32'h0);
        check_lit("d24_reg23", bbus_w[2], 32'hA5A50017);
        check_lit("d32_reg30", abus_w[0], 32'hDEADBEEF);
        tick();
        for (int i = 0; i < 32; i++) begin
            aaddr = 5'(i);
            baddr = 5'(i);
            tick();
        end

        // Same-cycle write/read hazard on register 5.
        do_write(5'd5, 32'h11111111);
        dwe = 1'b1; daddr = 5'd5; dbus = 32'h22222222; aaddr = 5'd5; baddr = 5'd5;
        @(negedge clk);
        check_lit("hazard_same", abus_w[0], BYPASS ? 32'h22222222 : 32'h11111111);
        tick();
        dwe = 1'b0;
        @(negedge clk);
        check_lit("hazard_next", abus_w[0], 32'h22222222);
        check_lit("hazard_next_b", bbus_w[2], 32'h22222222);
        tick();

        // Reset beats a simultaneous write.
        do_write(5'd7, 32'h0000BEEF);
        reset = 1'b1; dwe = 1'b1; daddr = 5'd7; dbus = 32'h12345678; aaddr = 5'd7;
        @(negedge clk);
        check_lit("rst_cycle_read", abus_w[0], 32'h0000BEEF);
        tick();
        reset = 1'b0; dwe = 1'b0;
        @(negedge clk);
        check_lit("rst_beats_wr", abus_w[0], 32'h0);
        check_lit("rst_beats_wr1", abus_w[1], 32'h0);
        tick();

        // Random traffic, biased toward read/write address collisions.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(63) == 0);
            dwe   = 1'($urandom_range(1));
            daddr = 5'($urandom_range(31));
            dbus  = $urandom;
            aaddr = ($urandom_range(3) == 0) ? daddr : 5'($urandom_range(31));
            baddr = ($urandom_range(3) == 0) ? daddr : 5'($urandom_range(31));
            tick();
        end
        reset = 1'b0; dwe = 1'b0;
        tick();
        checking = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
